// File: rtl/fp_pkg.sv
// Shared FSM/class types, operand classifier, canonical qNaN builder and flag indices.
// Latency: none, declarations only.
// Backpressure: not applicable.
package fp_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MUL,
        ST_RND,
        ST_DONE
    } state_t;

    typedef enum logic [2:0] {
        CLS_ZERO,
        CLS_NORM,
        CLS_INF,
        CLS_QNAN,
        CLS_SNAN
    } op_class_t;

    // Bit positions inside flags = {invalid, overflow, underflow, inexact}
    localparam int FLG_INVALID   = 3;
    localparam int FLG_OVERFLOW  = 2;
    localparam int FLG_UNDERFLOW = 1;
    localparam int FLG_INEXACT   = 0;

    // Denormals (exp==0) are treated as zero regardless of fraction.
    function automatic op_class_t classify(input logic exp_zero,
                                           input logic exp_ones,
                                           input logic frac_zero,
                                           input logic frac_msb);
        op_class_t cls;
        if (exp_zero)
            cls = CLS_ZERO;
        else if (!exp_ones)
            cls = CLS_NORM;
        else if (frac_zero)
            cls = CLS_INF;
        else if (frac_msb)
            cls = CLS_QNAN;
        else
            cls = CLS_SNAN;
        return cls;
    endfunction

    // {0, all-ones exponent, 1, zeros}, right-aligned in 64 bits.
    function automatic logic [63:0] qnan_bits(input int exp_w, input int man_w);
        logic [63:0] v;
        v = ((64'd1 << exp_w) - 64'd1) << man_w;
        v = v | (64'd1 << (man_w - 1));
        return v;
    endfunction

endpackage

// File: rtl/fp_mant_seq_mul.sv
// Unsigned NxN sequential shift-add multiplier, one multiplier bit per cycle.
// Latency: N cycles after start; done is high in the cycle whose edge completes p.
// Backpressure: none; p holds until the next start.
module fp_mant_seq_mul #(
    parameter int N = 24
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    output logic           busy,
    output logic           done,
    output logic [2*N-1:0] p
);

    localparam int CW = (N > 1) ? $clog2(N) : 1;

    logic [N-1:0]   mcand;
    logic [2*N-1:0] acc;
    logic [CW-1:0]  cnt;
    logic           busy_q;
    logic [N:0]     sum;

    // Upper half accumulates the multiplicand, lower half shifts the multiplier out.
    always_comb begin
        sum = {1'b0, acc[2*N-1:N]};
        if (acc[0])
            sum = {1'b0, acc[2*N-1:N]} + {1'b0, mcand};
    end

    assign done = busy_q && (cnt == CW'(N - 1));
    assign busy = busy_q;
    assign p    = acc;

    always_ff @(posedge clk) begin
        if (rst) begin
            mcand  <= '0;
            acc    <= '0;
            cnt    <= '0;
            busy_q <= 1'b0;
        end else if (start) begin
            mcand  <= a;
            acc    <= {{N{1'b0}}, b};
            cnt    <= '0;
            busy_q <= 1'b1;
        end else if (busy_q) begin
            acc <= {sum, acc[N-1:1]};
            cnt <= cnt + CW'(1);
            if (done)
                busy_q <= 1'b0;
        end
    end

endmodule

// File: rtl/fp_mul_pipe_rne.sv
// Floating-point multiplier with round-to-nearest-even and IEEE exception flags.
// Latency: MAN_W+3 cycles to out_valid for normal operands, 1 cycle for special operands.
// Backpressure: result held in DONE until out_ready; in_ready low whenever an op is in flight.
module fp_mul_pipe_rne
    import fp_pkg::*;
#(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    parameter int BIAS  = 2**(EXP_W-1) - 1,
    parameter int W     = 1 + EXP_W + MAN_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] c,
    output logic [3:0]   flags
);

    localparam int M   = MAN_W + 1;
    localparam int EW2 = EXP_W + 2;
    localparam logic [63:0]           QNAN64  = qnan_bits(EXP_W, MAN_W);
    localparam logic [W-1:0]          QNAN    = QNAN64[W-1:0];
    localparam logic signed [EW2-1:0] EXP_MAX = EW2'((1 << EXP_W) - 1);

    state_t state, state_nxt;

    logic [EXP_W-1:0] a_exp, b_exp;
    logic [MAN_W-1:0] a_frac, b_frac;
    op_class_t        a_cls, b_cls;
    logic             accept, special, sign_ab;
    logic             a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
    logic [W-1:0]     sp_c;
    logic [3:0]       sp_flags;

    logic signed [EW2-1:0] exp_sum, exp_q;
    logic                  sign_q;

    logic             mul_busy, mul_done;
    logic [2*M-1:0]   prod;

    assign a_exp  = a[W-2 -: EXP_W];
    assign b_exp  = b[W-2 -: EXP_W];
    assign a_frac = a[MAN_W-1:0];
    assign b_frac = b[MAN_W-1:0];

    assign a_cls = classify(a_exp == '0, &a_exp, a_frac == '0, a_frac[MAN_W-1]);
    assign b_cls = classify(b_exp == '0, &b_exp, b_frac == '0, b_frac[MAN_W-1]);

    assign a_nan  = (a_cls == CLS_QNAN) || (a_cls == CLS_SNAN);
    assign b_nan  = (b_cls == CLS_QNAN) || (b_cls == CLS_SNAN);
    assign a_inf  = (a_cls == CLS_INF);
    assign b_inf  = (b_cls == CLS_INF);
    assign a_zero = (a_cls == CLS_ZERO);
    assign b_zero = (b_cls == CLS_ZERO);

    assign sign_ab  = a[W-1] ^ b[W-1];
    assign special  = (a_cls != CLS_NORM) || (b_cls != CLS_NORM);
    assign in_ready = (state == ST_IDLE) && !rst && !mul_busy;
    assign accept   = in_valid && in_ready;
    assign out_valid = (state == ST_DONE);

    assign exp_sum = $signed({2'b00, a_exp}) + $signed({2'b00, b_exp}) - $signed(EW2'(BIAS));

    // Special-operand result; NaN takes priority over inf*zero, which beats plain inf/zero.
    always_comb begin
        sp_c     = '0;
        sp_flags = '0;
        if (a_nan || b_nan) begin
            sp_c = QNAN;
            sp_flags[FLG_INVALID] = (a_cls == CLS_SNAN) || (b_cls == CLS_SNAN);
        end else if ((a_inf && b_zero) || (a_zero && b_inf)) begin
            sp_c = QNAN;
            sp_flags[FLG_INVALID] = 1'b1;
        end else if (a_inf || b_inf) begin
            sp_c = {sign_ab, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end else begin
            sp_c = {sign_ab, {(W-1){1'b0}}};
        end
    end

    fp_mant_seq_mul #(.N(M)) u_mant (
        .clk   (clk),
        .rst   (rst),
        .start (accept && !special),
        .a     ({1'b1, a_frac}),
        .b     ({1'b1, b_frac}),
        .busy  (mul_busy),
        .done  (mul_done),
        .p     (prod)
    );

    // Normalise, round-to-nearest-even, exponent range check.
    logic [2*M-1:0]        norm;
    logic signed [EW2-1:0] exp_n, exp_f;
    logic [MAN_W-1:0]      frac;
    logic [MAN_W:0]        frac_inc;
    logic                  guard, sticky, rnd_up;
    logic [W-1:0]          rnd_c;
    logic [3:0]            rnd_flags;

    always_comb begin
        norm      = prod[2*M-1] ? prod : {prod[2*M-2:0], 1'b0};
        exp_n     = exp_q + {{(EW2-1){1'b0}}, prod[2*M-1]};
        frac      = norm[2*M-2:M];
        guard     = norm[M-1];
        sticky    = |norm[M-2:0];
        rnd_up    = guard && (sticky || frac[0]);
        frac_inc  = {1'b0, frac} + {{MAN_W{1'b0}}, rnd_up};
        exp_f     = exp_n + {{(EW2-1){1'b0}}, frac_inc[MAN_W]};
        rnd_c     = {sign_q, exp_f[EXP_W-1:0], frac_inc[MAN_W-1:0]};
        rnd_flags = '0;
        rnd_flags[FLG_INEXACT] = guard || sticky;
        if (exp_f >= EXP_MAX) begin
            rnd_c = {sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            rnd_flags[FLG_OVERFLOW] = 1'b1;
            rnd_flags[FLG_INEXACT]  = 1'b1;
        end else if (exp_f[EW2-1] || (exp_f == '0)) begin
            rnd_c = {sign_q, {(W-1){1'b0}}};
            rnd_flags[FLG_UNDERFLOW] = 1'b1;
            rnd_flags[FLG_INEXACT]   = 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (accept)    state_nxt = special ? ST_DONE : ST_MUL;
            ST_MUL:  if (mul_done)  state_nxt = ST_RND;
            ST_RND:                 state_nxt = ST_DONE;
            ST_DONE: if (out_ready) state_nxt = ST_IDLE;
            default:                state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            c      <= '0;
            flags  <= '0;
            exp_q  <= '0;
            sign_q <= 1'b0;
        end else begin
            if (accept) begin
                exp_q  <= exp_sum;
                sign_q <= sign_ab;
                if (special) begin
                    c     <= sp_c;
                    flags <= sp_flags;
                end
            end
            if (state == ST_RND) begin
                c     <= rnd_c;
                flags <= rnd_flags;
            end
        end
    end

endmodule

// File: tb/tb_fp_mul_pipe_rne.sv
// Directed-vector bench for fp_mul_pipe_rne (single precision defaults).
module tb_fp_mul_pipe_rne;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] c;
    logic [3:0]  flags;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    fp_mul_pipe_rne dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .c         (c),
        .flags     (flags)
    );

    task automatic chk(input logic [31:0] obs, input logic [31:0] expv, input string tag);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic run_op(input logic [31:0] xa, input logic [31:0] xb,
                          input logic [31:0] ec, input logic [3:0] ef,
                          input int el, input string tag, input bit do_hs);
        int lat;
        @(negedge clk);
        a         = xa;
        b         = xb;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        chk({31'd0, in_ready}, 32'd1, {tag, "_in_ready"});
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = 1;
        while (out_valid !== 1'b1 && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk(32'(lat), 32'(el), {tag, "_latency"});
        chk(c, ec, {tag, "_c"});
        chk({28'd0, flags}, {28'd0, ef}, {tag, "_flags"});
        if (do_hs) begin
            @(negedge clk);
            out_ready = 1'b1;
            @(posedge clk);
            #1;
            out_ready = 1'b0;
            chk({31'd0, out_valid}, 32'd0, {tag, "_drop"});
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] held_c;
        logic [3:0]  held_f;

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;

        repeat (3) @(posedge clk);
        #1;
        chk({31'd0, in_ready},  32'd0, "rst_in_ready");
        chk({31'd0, out_valid}, 32'd0, "rst_out_valid");
        chk(c,                  32'd0, "rst_c");
        chk({28'd0, flags},     32'd0, "rst_flags");
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk({31'd0, in_ready},  32'd1, "post_rst_in_ready");

        // Normal operands
        run_op(32'h3FC00000, 32'h40000000, 32'h40400000, 4'b0000, 26, "mul_1p5x2",   1);
        run_op(32'h3F800001, 32'h3F800001, 32'h3F800002, 4'b0001, 26, "sticky_only", 1);
        run_op(32'h3FFFFFFF, 32'h3FFFFFFF, 32'h407FFFFE, 4'b0001, 26, "norm_shift",  1);
        run_op(32'h3F800001, 32'h3FC00000, 32'h3FC00002, 4'b0001, 26, "tie_up_even", 1);
        run_op(32'h3F800003, 32'h3FC00000, 32'h3FC00004, 4'b0001, 26, "tie_keep",    1);
        run_op(32'h3FFFFFFF, 32'h3F800001, 32'h40000000, 4'b0001, 26, "rnd_carry",   1);
        run_op(32'h7F000000, 32'h7F000000, 32'h7F800000, 4'b0101, 26, "overflow",    1);
        run_op(32'h00800000, 32'h00800000, 32'h00000000, 4'b0011, 26, "underflow",   1);

        // Special operands
        run_op(32'h7F800000, 32'h00000000, 32'h7FC00000, 4'b1000, 1, "inf_x_zero",  1);
        run_op(32'h80000000, 32'h3F800000, 32'h80000000, 4'b0000, 1, "negzero",     1);
        run_op(32'hFF800000, 32'h40000000, 32'hFF800000, 4'b0000, 1, "neg_inf",     1);
        run_op(32'h7F800001, 32'h3F800000, 32'h7FC00000, 4'b1000, 1, "snan",        1);
        run_op(32'h7FC00000, 32'h00000000, 32'h7FC00000, 4'b0000, 1, "qnan_x_zero", 1);

        // Backpressure: hold DONE, offer a competing operand pair
        run_op(32'h40400000, 32'h40400000, 32'h41100000, 4'b0000, 26, "bp", 0);
        held_c = c;
        held_f = flags;
        @(negedge clk);
        a        = 32'h3F800000;
        b        = 32'h40000000;
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            chk({c[31:0]}, 32'h41100000, "bp_hold_c");
            chk({26'd0, flags, in_ready, out_valid}, {26'd0, held_f, 1'b0, 1'b1}, "bp_hold_ctl");
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk({30'd0, in_ready, out_valid}, 32'b10, "bp_release");
        repeat (4) @(posedge clk);
        #1;
        chk({31'd0, out_valid}, 32'd0, "bp_no_phantom");
        chk(c, held_c, "bp_c_kept");

        // Reset in the middle of MUL
        @(negedge clk);
        a        = 32'h40400000;
        b        = 32'h40000000;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk({30'd0, in_ready, out_valid}, 32'd0, "midrst_outputs");
        chk(c, 32'd0, "midrst_c");
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk({31'd0, in_ready}, 32'd1, "midrst_release");
        run_op(32'h3F800000, 32'h3F800000, 32'h3F800000, 4'b0000, 26, "after_rst", 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
